// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin front end for a shared binary<->Gray converter.
// Define GRAY_ARB_CHECK_EN to build the round-trip checker behind o_chk_err.

module bin_to_gray #(
   parameter int BW_DATA = 8
) (
   input  logic [BW_DATA-1:0] bin,
   output logic [BW_DATA-1:0] gray
);
   assign gray = bin ^ (bin >> 1);
endmodule

module gray_to_bin #(
   parameter int BW_DATA = 8
) (
   input  logic [BW_DATA-1:0] gray,
   output logic [BW_DATA-1:0] bin
);
   // bit k is the XOR of every Gray bit from k up to the MSB
   always_comb begin
      bin = '0;
      for (int k = 0; k < BW_DATA; k++)
         bin[k] = ^(gray >> k);
   end
endmodule

module gray_conv_arbiter #(
   parameter int BW_DATA = 8
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_req0_valid,
   input  logic [BW_DATA-1:0] i_req0_data,
   input  logic               i_req0_mode,
   output logic               o_req0_ready,
   input  logic               i_req1_valid,
   input  logic [BW_DATA-1:0] i_req1_data,
   input  logic               i_req1_mode,
   output logic               o_req1_ready,
   output logic               o_valid,
   output logic [BW_DATA-1:0] o_data,
   output logic               o_id,
   output logic               o_mode,
   input  logic               i_ready,
   output logic               o_chk_err
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]         state;
   logic               rr_ptr;
   logic               can_accept;
   logic               grant0;
   logic               grant1;
   logic               grant;
   logic [BW_DATA-1:0] sel_data;
   logic               sel_mode;
   logic [BW_DATA-1:0] b2g;
   logic [BW_DATA-1:0] g2b;
   logic [BW_DATA-1:0] conv;

   assign o_valid    = (state == FULL);
   assign can_accept = !o_valid || i_ready;

   // rr_ptr only breaks ties; a lone requester always wins
   assign grant0 = can_accept && i_req0_valid &&
                   (!i_req1_valid || !rr_ptr);
   assign grant1 = can_accept && i_req1_valid &&
                   (!i_req0_valid || rr_ptr);
   assign grant  = grant0 || grant1;

   assign o_req0_ready = grant0;
   assign o_req1_ready = grant1;

   assign sel_data = grant1 ? i_req1_data : i_req0_data;
   assign sel_mode = grant1 ? i_req1_mode : i_req0_mode;

   bin_to_gray #(.BW_DATA(BW_DATA)) u_b2g (
      .bin  (sel_data),
      .gray (b2g)
   );

   gray_to_bin #(.BW_DATA(BW_DATA)) u_g2b (
      .gray (sel_data),
      .bin  (g2b)
   );

   assign conv = sel_mode ? g2b : b2g;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state  <= EMPTY;
         rr_ptr <= 1'b0;
         o_data <= '0;
         o_id   <= 1'b0;
         o_mode <= 1'b0;
      end else begin
         if (grant) begin
            o_data <= conv;
            o_id   <= grant1;
            o_mode <= sel_mode;
            rr_ptr <= !grant1;
         end
         case (state)
            EMPTY:   if (grant) state <= FULL;
            FULL:    if (i_ready && !grant) state <= EMPTY;
            default: state <= EMPTY;
         endcase
      end
   end

`ifdef GRAY_ARB_CHECK_EN
   logic [BW_DATA-1:0] orig_q;
   logic [BW_DATA-1:0] inv_b2g;
   logic [BW_DATA-1:0] inv_g2b;
   logic [BW_DATA-1:0] inv;
   logic               chk_err_q;

   bin_to_gray #(.BW_DATA(BW_DATA)) u_inv_b2g (
      .bin  (o_data),
      .gray (inv_b2g)
   );

   gray_to_bin #(.BW_DATA(BW_DATA)) u_inv_g2b (
      .gray (o_data),
      .bin  (inv_g2b)
   );

   assign inv = o_mode ? inv_b2g : inv_g2b;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         orig_q    <= '0;
         chk_err_q <= 1'b0;
      end else begin
         if (grant) orig_q <= sel_data;
         if (o_valid && (inv != orig_q)) chk_err_q <= 1'b1;
      end
   end

   assign o_chk_err = chk_err_q;
`else
   assign o_chk_err = 1'b0;
`endif

endmodule
